// File: rtl/ft245s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ft245s_pkg
//  Description : State encoding for the FT245-style host bus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ft245s_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_OE  = 3'd1,
        RD     = 3'd2,
        RD_END = 3'd3,
        WR     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ft245s_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ft245s_fifo
//  Description : Synchronous first-word-fall-through FIFO with full, empty
//                and free-slot outputs. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module ft245s_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_DEPTH_W = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]    c_CNT_ONE = (c_AW + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Requests are ignored when they cannot be honoured, so callers may be sloppy
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_DEPTH_W);
    assign o_empty = (r_count == '0);
    assign o_free  = c_DEPTH_W - r_count;

    // Storage array, written at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ft245s_modport.sv
`default_nettype none
// ============================================================================
//  Module      : ft245s_modport
//  Description : FT245-style synchronous host bus controller. Bridges the
//                host strobe bus to a pair of valid/ready user streams through
//                an rx and a tx FIFO. Reads take priority over writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ft245s_modport #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxfn,
    input  logic              txen,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rdn,
    output logic              wrn,
    output logic              oen,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready
);

    import ft245s_pkg::*;

    localparam int            c_AW       = $clog2(FIFO_DEPTH);
    // A read burst never lets the rx FIFO drop below one free slot
    localparam logic [c_AW:0] c_MIN_FREE = (c_AW + 1)'(2);
    // Free count when exactly one word remains in the tx FIFO
    localparam logic [c_AW:0] c_ONE_USED = (c_AW + 1)'(FIFO_DEPTH - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_dout;

    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [c_AW:0]     w_rx_free;
    logic [c_AW:0]     w_rx_free_after;

    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_tx_last;
    logic [c_AW:0]     w_tx_free;
    logic [DATA_W-1:0] w_tx_head;

    assign w_rx_push       = (r_state == RD) && !rdn && !rxfn && !w_rx_full;
    assign rx_valid        = !w_rx_empty;
    assign w_rx_pop        = rx_valid && rx_ready;
    // Pops in the same cycle are ignored here, so this errs on the safe side
    assign w_rx_free_after = w_rx_free - (c_AW + 1)'(w_rx_push);

    assign tx_ready        = !w_tx_full;
    assign w_tx_push       = tx_valid && tx_ready;
    assign w_tx_pop        = (r_state == WR) && !wrn && !txen;
    // The word being consumed is the last one and nothing refills behind it
    assign w_tx_last       = (w_tx_free == c_ONE_USED) && !w_tx_push;

    // While writing the bus shows the FIFO head; otherwise the last word sent
    assign dout            = (r_state == WR) ? w_tx_head : r_dout;

    ft245s_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rx_push),
        .i_push_data (din),
        .i_pop       (w_rx_pop),
        .o_head      (rx_data),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_free      (w_rx_free)
    );

    ft245s_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_tx_push),
        .i_push_data (tx_data),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_free      (w_tx_free)
    );

    // Bus sequencer: strobes and the held dout value are all registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            rdn     <= 1'b1;
            wrn     <= 1'b1;
            oen     <= 1'b1;
            r_dout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!rxfn && (w_rx_free >= c_MIN_FREE)) begin
                        oen     <= 1'b0;
                        r_state <= RD_OE;
                    end else if (!txen && !w_tx_empty) begin
                        wrn     <= 1'b0;
                        r_state <= WR;
                    end
                end
                RD_OE: begin
                    rdn     <= 1'b0;
                    r_state <= RD;
                end
                RD: begin
                    if (rxfn || (w_rx_free_after < c_MIN_FREE)) begin
                        rdn     <= 1'b1;
                        r_state <= RD_END;
                    end
                end
                RD_END: begin
                    // Host bus turnaround: oen released before any write
                    oen     <= 1'b1;
                    r_state <= IDLE;
                end
                WR: begin
                    // Only a consumed word may end the burst or let a read in
                    if (w_tx_pop) begin
                        r_dout <= w_tx_head;
                        if (w_tx_last || !rxfn) begin
                            wrn     <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    rdn     <= 1'b1;
                    wrn     <= 1'b1;
                    oen     <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ft245s_modport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ft245s_modport
//  Description : Directed self-checking bench for ft245s_modport with a
//                cycle-stepped host model and user stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ft245s_modport;

    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            rxfn;
    logic            txen;
    logic [c_DW-1:0] din;
    logic [c_DW-1:0] dout;
    logic            rdn;
    logic            wrn;
    logic            oen;
    logic [c_DW-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [c_DW-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;

    ft245s_modport #(
        .DATA_W     (c_DW),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxfn     (rxfn),
        .txen     (txen),
        .din      (din),
        .dout     (dout),
        .rdn      (rdn),
        .wrn      (wrn),
        .oen      (oen),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    logic [c_DW-1:0] host_q [$];   // words the host still has to send
    logic [c_DW-1:0] tx_src [$];   // words the user still has to push
    logic [c_DW-1:0] rx_log [$];   // words the user received
    logic [c_DW-1:0] wr_log [$];   // words the host captured

    int  n_chk  = 0;
    int  n_pass = 0;
    int  proto_err = 0;
    int  cyc = 0;
    int  last_rd_cyc;
    int  first_wr_cyc;
    logic prev_oen = 1'b1, prev2_oen = 1'b1, prev_rdn = 1'b1, prev_wrn = 1'b1;

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [c_DW-1:0] at(input logic [c_DW-1:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic drive();
        rxfn     = (host_q.size() == 0);
        din      = (host_q.size() != 0) ? host_q[0] : '0;
        tx_valid = (tx_src.size() != 0);
        tx_data  = (tx_src.size() != 0) ? tx_src[0] : '0;
    endtask

    // One clock: observe at the falling edge, update stimulus just after the rising edge
    task automatic step();
        logic rd_take, wr_take, usr_rx, usr_tx;
        @(negedge clk);
        rd_take = !rdn && !rxfn;
        wr_take = !wrn && !txen;
        usr_rx  = rx_valid && rx_ready;
        usr_tx  = tx_valid && tx_ready;
        if (prev_rdn && !rdn && !(prev_oen == 1'b0 && prev2_oen == 1'b1)) proto_err++;
        if (prev_wrn && !wrn && !(prev_oen == 1'b1 && oen == 1'b1)) proto_err++;
        if (!rdn && !wrn) proto_err++;
        if (!wrn && !oen) proto_err++;
        prev2_oen = prev_oen;
        prev_oen  = oen;
        prev_rdn  = rdn;
        prev_wrn  = wrn;
        if (wr_take) begin
            wr_log.push_back(dout);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (rd_take) last_rd_cyc = cyc;
        if (usr_rx) rx_log.push_back(rx_data);
        @(posedge clk);
        #1;
        cyc++;
        if (rd_take) void'(host_q.pop_front());
        if (usr_tx) void'(tx_src.pop_front());
        drive();
    endtask

    initial begin
        rst = 1'b1;
        txen = 1'b1;
        rx_ready = 1'b1;
        first_wr_cyc = -1;
        last_rd_cyc = -1;
        drive();
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_rdn", 32'(rdn), 32'd1);
        check("rst_wrn", 32'(wrn), 32'd1);
        check("rst_oen", 32'(oen), 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        step();

        // Four-word host read burst
        host_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        drive();
        for (int i = 0; i < 100 && rx_log.size() < 4; i++) step();
        check("rd4_size", 32'(rx_log.size()), 32'd4);
        check("rd4_w0", at(rx_log, 0), 32'h11111111);
        check("rd4_w1", at(rx_log, 1), 32'h22222222);
        check("rd4_w2", at(rx_log, 2), 32'h33333333);
        check("rd4_w3", at(rx_log, 3), 32'h44444444);
        check("rd4_proto", 32'(proto_err), 32'd0);

        // Eight words queued while the host is not ready, then released
        for (int i = 0; i < 8; i++) tx_src.push_back(32'(i));
        drive();
        repeat (20) step();
        check("wr8_hold_wrn", 32'(wrn), 32'd1);
        check("wr8_hold_cnt", 32'(wr_log.size()), 32'd0);
        txen = 1'b0;
        for (int i = 0; i < 100 && wr_log.size() < 8; i++) step();
        repeat (5) step();
        check("wr8_size", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("wr8_w%0d", i), at(wr_log, i), 32'(i));
        check("wr8_last_dout", dout, 32'd7);

        // Host stalls after three words of an eight-word burst
        wr_log.delete();
        txen = 1'b1;
        for (int i = 0; i < 8; i++) tx_src.push_back(32'hA0 + 32'(i));
        drive();
        repeat (20) step();
        txen = 1'b0;
        for (int i = 0; i < 100 && wr_log.size() < 3; i++) step();
        txen = 1'b1;
        repeat (5) step();
        check("stall_wrn", 32'(wrn), 32'd0);
        check("stall_dout", dout, 32'hA3);
        check("stall_cnt", 32'(wr_log.size()), 32'd3);
        txen = 1'b0;
        for (int i = 0; i < 100 && wr_log.size() < 8; i++) step();
        repeat (5) step();
        check("stall_size", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("stall_w%0d", i), at(wr_log, i), 32'hA0 + 32'(i));

        // Twenty words into a sixteen-deep rx FIFO with the user stalled
        rx_log.delete();
        rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) host_q.push_back(32'h100 + 32'(i));
        drive();
        repeat (60) step();
        check("ovf_left", 32'(host_q.size()), 32'd5);
        check("ovf_rdn", 32'(rdn), 32'd1);
        check("ovf_oen", 32'(oen), 32'd1);
        check("ovf_rx_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 300 && rx_log.size() < 20; i++) step();
        check("ovf_size", 32'(rx_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) check($sformatf("ovf_w%0d", i), at(rx_log, i), 32'h100 + 32'(i));

        // Read and write requests arriving together
        rx_log.delete();
        wr_log.delete();
        txen = 1'b1;
        tx_src = '{32'hB0, 32'hB1};
        drive();
        repeat (10) step();
        first_wr_cyc = -1;
        last_rd_cyc = -1;
        host_q = '{32'hC0, 32'hC1, 32'hC2};
        txen = 1'b0;
        drive();
        for (int i = 0; i < 100 && (wr_log.size() < 2 || rx_log.size() < 3); i++) step();
        check("both_rx0", at(rx_log, 0), 32'hC0);
        check("both_rx1", at(rx_log, 1), 32'hC1);
        check("both_rx2", at(rx_log, 2), 32'hC2);
        check("both_wr0", at(wr_log, 0), 32'hB0);
        check("both_wr1", at(wr_log, 1), 32'hB1);
        check("both_rd_first", 32'((last_rd_cyc >= 0) && (first_wr_cyc > last_rd_cyc + 2)), 32'd1);
        check("both_proto", 32'(proto_err), 32'd0);

        // Reset pulse in the middle of a read burst
        rx_log.delete();
        for (int i = 0; i < 10; i++) host_q.push_back(32'hE0 + 32'(i));
        drive();
        for (int i = 0; i < 100 && rx_log.size() < 2; i++) step();
        check("mid_rdn_low", 32'(rdn), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdn", 32'(rdn), 32'd1);
        check("mid_rst_wrn", 32'(wrn), 32'd1);
        check("mid_rst_oen", 32'(oen), 32'd1);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        host_q.delete();
        rx_log.delete();
        drive();
        repeat (2) step();
        rst = 1'b0;
        step();
        host_q = '{32'hD0, 32'hD1};
        drive();
        for (int i = 0; i < 100 && rx_log.size() < 2; i++) step();
        repeat (5) step();
        check("post_size", 32'(rx_log.size()), 32'd2);
        check("post_w0", at(rx_log, 0), 32'hD0);
        check("post_w1", at(rx_log, 1), 32'hD1);
        check("final_proto", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ft245s_modport.md
FT245S_MODPORT -- requirements
Module: ft245s_modport

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the FT245 data bus and of all user data words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: depth of each internal FIFO; power of two, at least 4.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, width 1: sole clock; all outputs change on its rising edge.
REQ-005 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port rxfn, input, width 1: low means the host has a word for the DUT.
REQ-007 SHALL have port txen, input, width 1: low means the host can accept a word.
REQ-008 SHALL have port din, input, width DATA_W: host-to-DUT data.
REQ-009 SHALL have port dout, output, width DATA_W: DUT-to-host data.
REQ-010 SHALL have port rdn, output, width 1: active-low read strobe.
REQ-011 SHALL have port wrn, output, width 1: active-low write strobe.
REQ-012 SHALL have port oen, output, width 1: active-low output enable; low means the host drives din.
REQ-013 SHALL have ports rx_data (output, DATA_W), rx_valid (output, 1) and rx_ready (input, 1): user stream of words received from the host.
REQ-014 SHALL have ports tx_data (input, DATA_W), tx_valid (input, 1) and tx_ready (output, 1): user stream of words to send to the host.

Function
REQ-015 SHALL transfer a user word on a clock edge where valid and ready are both high; rx_valid = rx FIFO not empty; tx_ready = tx FIFO not full.
REQ-016 SHALL implement the FSM states IDLE, RD_OE, RD, RD_END and WR; all of rdn, wrn and oen are registered.
REQ-017 IDLE: if rxfn is low and the rx FIFO has at least 2 free slots, go to RD_OE; else if txen is low and the tx FIFO is not empty, go to WR; reads have priority.
REQ-018 RD_OE: oen low and rdn high for exactly 1 cycle, then go to RD.
REQ-019 RD: oen and rdn low; push din into the rx FIFO on every edge where rdn and rxfn are both low.
REQ-020 RD: go to RD_END when rxfn is high, or when the rx FIFO free count would drop below 2.
REQ-021 RD_END: rdn high and oen still low for 1 cycle, then oen high and go to IDLE; this gives a turnaround of at least 1 cycle before any write.
REQ-022 WR: dout = tx FIFO head (first-word fall-through); wrn low.
REQ-023 WR: a word is consumed (popped) only on an edge where wrn and txen are both low; otherwise dout and wrn are held.
REQ-024 WR: wrn stays low while the FIFO stays non-empty, then returns to IDLE when the FIFO goes empty or rxfn goes low; a read may preempt only on the cycle after a consume.
REQ-025 SHALL assert wrn and rdn low in mutually exclusive cycles; wrn SHALL never be low while oen is low.
REQ-026 SHALL neither lose, duplicate nor reorder words in either direction.
REQ-027 SHALL never overflow the rx FIFO: din is not captured when the FIFO is full.
REQ-028 SHALL keep dout at its last value when idle.

Reset
REQ-029 While rst is high: rdn, wrn and oen = 1; dout = 0; both FIFOs empty (rx_valid = 0, tx_ready = 1); FSM = IDLE.
REQ-030 Reset mid-transfer SHALL take effect asynchronously and discard FIFO contents; operation resumes from IDLE on the first edge after rst falls.

Structure
REQ-031 SHALL place the FSM state enum, and no other types or constants, in package ft245s_pkg.
REQ-032 SHALL instantiate one sub-module, ft245s_fifo (a synchronous FWFT FIFO with full, empty and free-count outputs), twice: once for rx and once for tx.

Verification
REQ-033 Host sends 0x11111111, 0x22222222, 0x33333333, 0x44444444 with rx_ready = 1 -> the same 4 words appear on rx_data in order; oen falls exactly 1 cycle before rdn.
REQ-034 User pushes 8 words 0..7 while txen = 1 -> wrn stays high; then txen = 0 -> host captures 0..7 in order, each exactly once.
REQ-035 txen rises after 3 words are captured during an 8-word burst -> wrn and dout are held; the remaining 5 words are captured after txen falls, with no loss and no duplication.
REQ-036 rx_ready = 0 and the host sends 20 words with FIFO_DEPTH = 16 -> rdn rises before overflow; all 20 words are delivered in order after rx_ready = 1.
REQ-037 rxfn = 0 and tx FIFO holding 2 words in the same cycle -> the read burst completes first, then oen is high for at least 1 cycle, then both words are written.
REQ-038 rst is pulsed during a read burst -> rdn, wrn and oen = 1 immediately; rx_valid = 0; a subsequent 2-word send is received correctly.
